// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division (26 iterations)
// followed by a single round-to-nearest-even cycle; raw quotient feeds the export stage.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] temp_result,
  output logic [31:0] a_q,
  output logic [31:0] b_q
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on acceptance
  // DIV   | one restoring-division iteration per cycle, 26 in total
  // ROUND | normalize, RNE round, exponent limits, write temp_result
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, ROUND = 2'd2} state_t;

  state_t state, state_nxt;

  logic [24:0] rem;
  logic [25:0] q;
  logic [4:0]  cnt;
  logic        load, step, fin;

  logic [23:0] mb;
  logic        q_bit;
  logic [24:0] rem_sub;

  logic              sign;
  logic signed [9:0] ea, eb, exp_pre, exp_fin;
  logic [23:0]       mant;
  logic              guard, sticky, inc, carry;
  logic [22:0]       frac_inc, frac_fin;
  logic [31:0]       result;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (cnt == 5'd25) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      IDLE:    load = start;
      DIV:     step = 1'b1;
      ROUND:   fin  = 1'b1;
      default: ;
    endcase
  end

  // Divisor mantissa comes from the held operand copy, so it is stable for the whole run.
  assign mb      = {|b_q[30:23], b_q[22:0]};
  assign q_bit   = (rem >= {1'b0, mb});
  assign rem_sub = rem - (q_bit ? {1'b0, mb} : 25'd0);

  always_comb begin
    sign = a_q[31] ^ b_q[31];
    ea   = $signed({2'b00, a_q[30:23]});
    eb   = $signed({2'b00, b_q[30:23]});
    if (q[25]) begin
      mant    = q[25:2];
      guard   = q[1];
      sticky  = q[0] | (rem != 25'd0);
      exp_pre = ea - eb + 10'sd127;
    end else begin
      mant    = q[24:1];
      guard   = q[0];
      sticky  = (rem != 25'd0);
      exp_pre = ea - eb + 10'sd126;
    end
    inc      = guard & (sticky | mant[0]);
    carry    = inc & (&mant);
    frac_inc = mant[22:0] + {22'd0, inc};
    frac_fin = carry ? 23'd0 : frac_inc;
    exp_fin  = carry ? exp_pre + 10'sd1 : exp_pre;

    if (b_q[30:23] == 8'd0)      result = {sign, 8'hFF, 23'd0};
    else if (a_q[30:23] == 8'd0) result = {sign, 31'd0};
    else if (exp_fin >= 10'sd255) result = {sign, 8'hFF, 23'd0};
    else if (exp_fin <= 10'sd0)   result = {sign, 31'd0};
    else                          result = {sign, exp_fin[7:0], frac_fin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      temp_result <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rem         <= 25'd0;
      q           <= 26'd0;
      cnt         <= 5'd0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_q  <= A;
        b_q  <= B;
        rem  <= {1'b0, |A[30:23], A[22:0]};
        q    <= 26'd0;
        cnt  <= 5'd0;
        busy <= 1'b1;
      end
      if (step) begin
        rem <= rem_sub << 1;
        q   <= {q[24:0], q_bit};
        cnt <= cnt + 5'd1;
      end
      if (fin) begin
        temp_result <= result;
        done        <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expected quotients are pushed at issue time and
// popped when done pulses; control scenarios cover ignored start, back-to-back and reset abort.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, done;
  logic [31:0] temp_result, a_q, b_q;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } txn_t;

  txn_t sb[$];
  int compared = 0;
  int mismatched = 0;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .temp_result(temp_result), .a_q(a_q), .b_q(b_q)
  );

  always #5 clk = ~clk;

  // Present a start pulse; returns at edge E0 + 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    txn_t t;
    t.a = a; t.b = b; t.res = res;
    sb.push_back(t);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++; $display("FAIL reset_ctl: got busy/done %b want 00", {busy, done});
    end
    compared++;
    if ({temp_result, a_q, b_q} !== 96'd0) begin
      mismatched++; $display("FAIL reset_data: got %h %h %h want zeros", temp_result, a_q, b_q);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_arith;
    logic [31:0] vec [10][3];
    int   c;
    txn_t t;
    vec = '{'{32'h3F800000, 32'h3F800000, 32'h3F800000},
            '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB},
            '{32'h40C00000, 32'hC0000000, 32'hC0400000},
            '{32'h7F000000, 32'h00800000, 32'h7F800000},
            '{32'h00800000, 32'h7F000000, 32'h00000000},
            '{32'h3F800000, 32'h80000000, 32'hFF800000},
            '{32'h40000000, 32'h40800000, 32'h3F000000},
            '{32'hBF800000, 32'hBF800000, 32'h3F800000},
            '{32'h80000000, 32'h40A00000, 32'h80000000},
            '{32'h3FC00000, 32'h3F800000, 32'h3FC00000}};
    for (int i = 0; i < 10; i++) begin
      issue(vec[i][0], vec[i][1], vec[i][2]);
      compared++;
      if (busy !== 1'b1) begin
        mismatched++; $display("FAIL arith_busy[%0d]: got %b want 1", i, busy);
      end
      wait_done(c);
      compared++;
      if (c !== 27) begin
        mismatched++; $display("FAIL arith_latency[%0d]: got %0d want 27", i, c);
      end
      t = sb.pop_front();
      compared++;
      if (temp_result !== t.res) begin
        mismatched++; $display("FAIL arith_result[%0d]: got %h want %h", i, temp_result, t.res);
      end
      compared++;
      if ({a_q, b_q, busy} !== {t.a, t.b, 1'b0}) begin
        mismatched++; $display("FAIL arith_echo[%0d]: got %h %h busy=%b want %h %h busy=0",
                               i, a_q, b_q, busy, t.a, t.b);
      end
      @(posedge clk); #1;
      compared++;
      if ({done, temp_result} !== {1'b0, t.res}) begin
        mismatched++; $display("FAIL arith_pulse_hold[%0d]: got done=%b %h want done=0 %h",
                               i, done, temp_result, t.res);
      end
    end
  endtask

  task automatic test_ignore_start;
    int   c, pulses;
    txn_t t;
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    repeat (9) @(posedge clk);
    #1;
    A = 32'h40C00000; B = 32'hC0000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if ({busy, a_q, b_q} !== {1'b1, 32'h3F800000, 32'h40400000}) begin
      mismatched++; $display("FAIL ignore_inflight: got busy=%b %h %h want busy=1 3f800000 40400000",
                             busy, a_q, b_q);
    end
    wait_done(c);
    t = sb.pop_front();
    compared++;
    if (c + 10 !== 27) begin
      mismatched++; $display("FAIL ignore_latency: got %0d want 27", c + 10);
    end
    compared++;
    if (temp_result !== t.res) begin
      mismatched++; $display("FAIL ignore_result: got %h want %h", temp_result, t.res);
    end
    pulses = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("FAIL ignore_extra_done: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int   c;
    txn_t t;
    issue(32'h40C00000, 32'hC0000000, 32'hC0400000);
    wait_done(c);
    t = sb.pop_front();
    compared++;
    if ({done, temp_result, a_q, b_q} !== {1'b1, t.res, t.a, t.b}) begin
      mismatched++; $display("FAIL b2b_first: got done=%b %h %h %h want done=1 %h %h %h",
                             done, temp_result, a_q, b_q, t.res, t.a, t.b);
    end
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    compared++;
    if ({busy, a_q} !== {1'b1, 32'h3F800000}) begin
      mismatched++; $display("FAIL b2b_accept: got busy=%b a_q=%h want busy=1 3f800000", busy, a_q);
    end
    wait_done(c);
    t = sb.pop_front();
    compared++;
    if (c !== 27) begin
      mismatched++; $display("FAIL b2b_latency: got %0d want 27", c);
    end
    compared++;
    if (temp_result !== t.res) begin
      mismatched++; $display("FAIL b2b_result: got %h want %h", temp_result, t.res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int   c, pulses;
    txn_t t;
    issue(32'h7F000000, 32'h00800000, 32'h7F800000);
    void'(sb.pop_front());
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if ({busy, done, temp_result, a_q, b_q} !== 98'd0) begin
      mismatched++; $display("FAIL abort_state: got busy=%b done=%b %h %h %h want all zero",
                             busy, done, temp_result, a_q, b_q);
    end
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    compared++;
    if (pulses !== 0 || temp_result !== 32'd0) begin
      mismatched++; $display("FAIL abort_no_done: got %0d pulses result %h want 0 pulses 00000000",
                             pulses, temp_result);
    end
    issue(32'h40000000, 32'h40800000, 32'h3F000000);
    wait_done(c);
    t = sb.pop_front();
    compared++;
    if (c !== 27 || temp_result !== t.res) begin
      mismatched++; $display("FAIL abort_recover: got %0d cycles %h want 27 cycles %h",
                             c, temp_result, t.res);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    compared++;
    if (sb.size() !== 0) begin
      mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
